// File: rtl/ddr_axi_ch_arbiter.sv
// ddr_axi_ch_arbiter
// Merges NUM_CH AXI-style requesters onto the single address / write / read
// port of the ddr3 controller. Write and read addresses are arbitrated
// independently (round-robin or fixed priority). Each request is tagged with
// its channel index as ID. Write data and read returns are routed by ID. The
// number of outstanding bursts is limited per channel and per direction.
//
// Ports
//   core_clk, resetn          clock, async active-low reset
//   ch_aw*/ch_ar*             per-channel packed address requests (channel i at [i*W +: W])
//   ch_awready/ch_arready     one-cycle grant pulse per channel
//   ch_wdata/ch_wstrb         per-channel write data, selected by axi_wusero_id
//   ch_wready/ch_wlast        write beat taken / last beat, routed by ID
//   ch_rdata/ch_rvalid/ch_rlast  registered read return, routed by axi_rid
//   axi_aw*/axi_w*/axi_ar*/axi_r*  controller-side port
//   err_id                    sticky: out-of-range ID, or completion with nothing outstanding

// ddr_axi_ch_addr_arb
// One address direction: eligibility, winner selection, issue FSM and
// per-channel outstanding counters.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | no request held; grants the winner (ready pulse) if any eligible
//   ST_ISSUE | latched request driven with m_valid_o until m_ready_i
module ddr_axi_ch_addr_arb #(
    parameter int NUM_CH   = 3,
    parameter int ADDR_W   = 28,
    parameter int LEN_W    = 4,
    parameter int ARB_MODE = 0,
    parameter int MAX_OUTS = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NUM_CH*ADDR_W-1:0]   req_addr_i,
    input  logic [NUM_CH*LEN_W-1:0]    req_len_i,
    input  logic [NUM_CH-1:0]          req_ap_i,
    input  logic [NUM_CH-1:0]          req_valid_i,
    output logic [NUM_CH-1:0]          req_ready_o,
    input  logic                       cpl_valid_i,
    input  logic [3:0]                 cpl_id_i,
    output logic [ADDR_W-1:0]          m_addr_o,
    output logic [LEN_W-1:0]           m_len_o,
    output logic                       m_ap_o,
    output logic [3:0]                 m_id_o,
    output logic                       m_valid_o,
    input  logic                       m_ready_i,
    output logic                       underflow_o
);

    typedef enum logic {ST_IDLE = 1'b0, ST_ISSUE = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [3:0]          rr_q, rr_d;
    logic [3:0]          id_q, id_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic                ap_q, ap_d;
    logic                valid_q, valid_d;
    logic [3:0]          cnt_q [NUM_CH];
    logic [3:0]          cnt_d [NUM_CH];

    logic [15:0]         elig;
    logic                any_elig;
    logic [3:0]          base;
    logic [4:0]          idx;
    logic [3:0]          win;
    logic                grant;

    // Eligibility padded to 16 so the 4-bit winner index always fits.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            elig[i] = req_valid_i[i] && (cnt_q[i] < 4'(MAX_OUTS));
        end
        any_elig = |elig;
    end

    // Scan from the highest offset down so the nearest eligible channel at or
    // after base is the last assignment and wins.
    always_comb begin
        base = (ARB_MODE == 1) ? 4'd0 : rr_q;
        win  = '0;
        idx  = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = {1'b0, base} + 5'(k);
            if (idx >= 5'(NUM_CH)) begin
                idx = idx - 5'(NUM_CH);
            end
            if (elig[idx[3:0]]) begin
                win = idx[3:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        id_d        = id_q;
        addr_d      = addr_q;
        len_d       = len_q;
        ap_d        = ap_q;
        valid_d     = valid_q;
        grant       = 1'b0;
        req_ready_o = '0;
        unique case (state_q)
            ST_IDLE: begin
                // Gated by reset so the combinational grant stays low while held in reset.
                if (any_elig && rst_ni) begin
                    grant   = 1'b1;
                    id_d    = win;
                    valid_d = 1'b1;
                    state_d = ST_ISSUE;
                    for (int i = 0; i < NUM_CH; i++) begin
                        req_ready_o[i] = (win == 4'(i));
                        if (win == 4'(i)) begin
                            addr_d = req_addr_i[i*ADDR_W +: ADDR_W];
                            len_d  = req_len_i[i*LEN_W +: LEN_W];
                            ap_d   = req_ap_i[i];
                        end
                    end
                end
            end
            ST_ISSUE: begin
                if (m_ready_i) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                    rr_d    = (({1'b0, id_q} + 5'd1) >= 5'(NUM_CH)) ? 4'd0 : id_q + 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Simultaneous grant and completion leave the count unchanged; a
    // completion while the count is zero is flagged and never wraps.
    always_comb begin
        underflow_o = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (grant && (win == 4'(i)) && !(cpl_valid_i && (cpl_id_i == 4'(i)))) begin
                cnt_d[i] = cnt_q[i] + 4'd1;
            end else if (cpl_valid_i && (cpl_id_i == 4'(i)) && !(grant && (win == 4'(i)))) begin
                if (cnt_q[i] != 4'd0) begin
                    cnt_d[i] = cnt_q[i] - 4'd1;
                end
            end
            if (cpl_valid_i && (cpl_id_i == 4'(i)) && (cnt_q[i] == 4'd0)) begin
                underflow_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            rr_q    <= '0;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            ap_q    <= 1'b0;
            valid_q <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            ap_q    <= ap_d;
            valid_q <= valid_d;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign m_addr_o  = addr_q;
    assign m_len_o   = len_q;
    assign m_ap_o    = ap_q;
    assign m_id_o    = id_q;
    assign m_valid_o = valid_q;

endmodule

module ddr_axi_ch_arbiter #(
    parameter int NUM_CH   = 3,
    parameter int ADDR_W   = 28,
    parameter int DATA_W   = 256,
    parameter int LEN_W    = 4,
    parameter int ARB_MODE = 0,
    parameter int MAX_OUTS = 4
) (
    input  logic                           core_clk,
    input  logic                           resetn,
    input  logic [NUM_CH*ADDR_W-1:0]       ch_awaddr,
    input  logic [NUM_CH*LEN_W-1:0]        ch_awlen,
    input  logic [NUM_CH-1:0]              ch_awap,
    input  logic [NUM_CH-1:0]              ch_awvalid,
    output logic [NUM_CH-1:0]              ch_awready,
    input  logic [NUM_CH*DATA_W-1:0]       ch_wdata,
    input  logic [NUM_CH*(DATA_W/8)-1:0]   ch_wstrb,
    output logic [NUM_CH-1:0]              ch_wready,
    output logic [NUM_CH-1:0]              ch_wlast,
    input  logic [NUM_CH*ADDR_W-1:0]       ch_araddr,
    input  logic [NUM_CH*LEN_W-1:0]        ch_arlen,
    input  logic [NUM_CH-1:0]              ch_arap,
    input  logic [NUM_CH-1:0]              ch_arvalid,
    output logic [NUM_CH-1:0]              ch_arready,
    output logic [DATA_W-1:0]              ch_rdata,
    output logic [NUM_CH-1:0]              ch_rvalid,
    output logic [NUM_CH-1:0]              ch_rlast,
    output logic [ADDR_W-1:0]              axi_awaddr,
    output logic [LEN_W-1:0]               axi_awlen,
    output logic                           axi_awuser_ap,
    output logic [3:0]                     axi_awuser_id,
    output logic                           axi_awvalid,
    input  logic                           axi_awready,
    output logic [DATA_W-1:0]              axi_wdata,
    output logic [DATA_W/8-1:0]            axi_wstrb,
    input  logic                           axi_wready,
    input  logic [3:0]                     axi_wusero_id,
    input  logic                           axi_wusero_last,
    output logic [ADDR_W-1:0]              axi_araddr,
    output logic [LEN_W-1:0]               axi_arlen,
    output logic                           axi_aruser_ap,
    output logic [3:0]                     axi_aruser_id,
    output logic                           axi_arvalid,
    input  logic                           axi_arready,
    input  logic [DATA_W-1:0]              axi_rdata,
    input  logic [3:0]                     axi_rid,
    input  logic                           axi_rlast,
    input  logic                           axi_rvalid,
    output logic                           err_id
);

    localparam int STRB_W = DATA_W / 8;

    logic                wid_ok, rid_ok;
    logic                aw_uf, ar_uf;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   rdata_q;
    logic [NUM_CH-1:0]   rvalid_q, rvalid_d;
    logic [NUM_CH-1:0]   rlast_q, rlast_d;

    // 5-bit compare keeps NUM_CH=16 from aliasing to zero.
    assign wid_ok = ({1'b0, axi_wusero_id} < 5'(NUM_CH));
    assign rid_ok = ({1'b0, axi_rid} < 5'(NUM_CH));

    ddr_axi_ch_addr_arb #(
        .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .LEN_W(LEN_W),
        .ARB_MODE(ARB_MODE), .MAX_OUTS(MAX_OUTS)
    ) u_aw (
        .clk_i       (core_clk),
        .rst_ni      (resetn),
        .req_addr_i  (ch_awaddr),
        .req_len_i   (ch_awlen),
        .req_ap_i    (ch_awap),
        .req_valid_i (ch_awvalid),
        .req_ready_o (ch_awready),
        .cpl_valid_i (axi_wready & axi_wusero_last & wid_ok),
        .cpl_id_i    (axi_wusero_id),
        .m_addr_o    (axi_awaddr),
        .m_len_o     (axi_awlen),
        .m_ap_o      (axi_awuser_ap),
        .m_id_o      (axi_awuser_id),
        .m_valid_o   (axi_awvalid),
        .m_ready_i   (axi_awready),
        .underflow_o (aw_uf)
    );

    ddr_axi_ch_addr_arb #(
        .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .LEN_W(LEN_W),
        .ARB_MODE(ARB_MODE), .MAX_OUTS(MAX_OUTS)
    ) u_ar (
        .clk_i       (core_clk),
        .rst_ni      (resetn),
        .req_addr_i  (ch_araddr),
        .req_len_i   (ch_arlen),
        .req_ap_i    (ch_arap),
        .req_valid_i (ch_arvalid),
        .req_ready_o (ch_arready),
        .cpl_valid_i (axi_rvalid & axi_rlast & rid_ok),
        .cpl_id_i    (axi_rid),
        .m_addr_o    (axi_araddr),
        .m_len_o     (axi_arlen),
        .m_ap_o      (axi_aruser_ap),
        .m_id_o      (axi_aruser_id),
        .m_valid_o   (axi_arvalid),
        .m_ready_i   (axi_arready),
        .underflow_o (ar_uf)
    );

    // Write data mux: an out-of-range ID selects nothing and drives zero.
    always_comb begin
        axi_wdata = '0;
        axi_wstrb = '0;
        ch_wready = '0;
        ch_wlast  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (axi_wusero_id == 4'(i)) begin
                axi_wdata    = ch_wdata[i*DATA_W +: DATA_W];
                axi_wstrb    = ch_wstrb[i*STRB_W +: STRB_W];
                ch_wready[i] = axi_wready & resetn;
                ch_wlast[i]  = axi_wready & axi_wusero_last & resetn;
            end
        end
    end

    always_comb begin
        rvalid_d = '0;
        rlast_d  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            rvalid_d[i] = axi_rvalid & (axi_rid == 4'(i));
            rlast_d[i]  = axi_rvalid & axi_rlast & (axi_rid == 4'(i));
        end
        err_d = err_q | aw_uf | ar_uf | (axi_wready & ~wid_ok) | (axi_rvalid & ~rid_ok);
    end

    always_ff @(posedge core_clk or negedge resetn) begin
        if (!resetn) begin
            rdata_q  <= '0;
            rvalid_q <= '0;
            rlast_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            rdata_q  <= axi_rdata;
            rvalid_q <= rvalid_d;
            rlast_q  <= rlast_d;
            err_q    <= err_d;
        end
    end

    assign ch_rdata  = rdata_q;
    assign ch_rvalid = rvalid_q;
    assign ch_rlast  = rlast_q;
    assign err_id    = err_q;

endmodule

// File: tb/tb_ddr_axi_ch_arbiter.sv
module tb_ddr_axi_ch_arbiter;

    localparam int NC = 3;
    localparam int AW = 28;
    localparam int DW = 256;
    localparam int LW = 4;

    logic core_clk = 1'b0;
    logic resetn;
    always #5 core_clk = ~core_clk;

    logic [NC*AW-1:0]     ch_awaddr, ch_araddr;
    logic [NC*LW-1:0]     ch_awlen, ch_arlen;
    logic [NC-1:0]        ch_awap, ch_awvalid, ch_arap, ch_arvalid;
    logic [NC*DW-1:0]     ch_wdata;
    logic [NC*DW/8-1:0]   ch_wstrb;
    logic                 axi_awready, axi_wready, axi_wusero_last, axi_arready;
    logic [3:0]           axi_wusero_id, axi_rid;
    logic [DW-1:0]        axi_rdata;
    logic                 axi_rlast, axi_rvalid;

    // round-robin instance outputs
    logic [NC-1:0]   ch_awready, ch_wready, ch_wlast, ch_arready, ch_rvalid, ch_rlast;
    logic [DW-1:0]   ch_rdata, axi_wdata;
    logic [DW/8-1:0] axi_wstrb;
    logic [AW-1:0]   axi_awaddr, axi_araddr;
    logic [LW-1:0]   axi_awlen, axi_arlen;
    logic            axi_awuser_ap, axi_awvalid, axi_aruser_ap, axi_arvalid, err_id;
    logic [3:0]      axi_awuser_id, axi_aruser_id;

    // fixed-priority instance outputs
    logic [NC-1:0]   fp_awready, fp_wready, fp_wlast, fp_arready, fp_rvalid, fp_rlast;
    logic [DW-1:0]   fp_rdata, fp_wdata;
    logic [DW/8-1:0] fp_wstrb;
    logic [AW-1:0]   fp_awaddr, fp_araddr;
    logic [LW-1:0]   fp_awlen, fp_arlen;
    logic            fp_awap, fp_awvalid, fp_arap, fp_arvalid, fp_err;
    logic [3:0]      fp_awid, fp_arid;

    ddr_axi_ch_arbiter #(.NUM_CH(NC), .ARB_MODE(0), .MAX_OUTS(4)) u_dut (
        .core_clk(core_clk), .resetn(resetn),
        .ch_awaddr(ch_awaddr), .ch_awlen(ch_awlen), .ch_awap(ch_awap),
        .ch_awvalid(ch_awvalid), .ch_awready(ch_awready),
        .ch_wdata(ch_wdata), .ch_wstrb(ch_wstrb), .ch_wready(ch_wready), .ch_wlast(ch_wlast),
        .ch_araddr(ch_araddr), .ch_arlen(ch_arlen), .ch_arap(ch_arap),
        .ch_arvalid(ch_arvalid), .ch_arready(ch_arready),
        .ch_rdata(ch_rdata), .ch_rvalid(ch_rvalid), .ch_rlast(ch_rlast),
        .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awuser_ap(axi_awuser_ap),
        .axi_awuser_id(axi_awuser_id), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wready(axi_wready),
        .axi_wusero_id(axi_wusero_id), .axi_wusero_last(axi_wusero_last),
        .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_aruser_ap(axi_aruser_ap),
        .axi_aruser_id(axi_aruser_id), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rdata(axi_rdata), .axi_rid(axi_rid), .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid),
        .err_id(err_id)
    );

    ddr_axi_ch_arbiter #(.NUM_CH(NC), .ARB_MODE(1), .MAX_OUTS(4)) u_dut_fp (
        .core_clk(core_clk), .resetn(resetn),
        .ch_awaddr(ch_awaddr), .ch_awlen(ch_awlen), .ch_awap(ch_awap),
        .ch_awvalid(ch_awvalid), .ch_awready(fp_awready),
        .ch_wdata(ch_wdata), .ch_wstrb(ch_wstrb), .ch_wready(fp_wready), .ch_wlast(fp_wlast),
        .ch_araddr(ch_araddr), .ch_arlen(ch_arlen), .ch_arap(ch_arap),
        .ch_arvalid(ch_arvalid), .ch_arready(fp_arready),
        .ch_rdata(fp_rdata), .ch_rvalid(fp_rvalid), .ch_rlast(fp_rlast),
        .axi_awaddr(fp_awaddr), .axi_awlen(fp_awlen), .axi_awuser_ap(fp_awap),
        .axi_awuser_id(fp_awid), .axi_awvalid(fp_awvalid), .axi_awready(axi_awready),
        .axi_wdata(fp_wdata), .axi_wstrb(fp_wstrb), .axi_wready(axi_wready),
        .axi_wusero_id(axi_wusero_id), .axi_wusero_last(axi_wusero_last),
        .axi_araddr(fp_araddr), .axi_arlen(fp_arlen), .axi_aruser_ap(fp_arap),
        .axi_aruser_id(fp_arid), .axi_arvalid(fp_arvalid), .axi_arready(axi_arready),
        .axi_rdata(axi_rdata), .axi_rid(axi_rid), .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid),
        .err_id(fp_err)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [NC-1:0] v;
        logic [NC-1:0] l;
        logic [DW-1:0] d;
    } rbeat_t;

    int     q_rr[$];
    int     q_fp[$];
    rbeat_t q_rd[$];

    initial begin
        int     e, last_rr, last_fp, n, nv, nl;
        rbeat_t rb;
        logic   beat, lst;

        resetn          = 1'b0;
        ch_awaddr       = '0; ch_araddr = '0;
        ch_awlen        = '0; ch_arlen  = '0;
        ch_awap         = '0; ch_arap   = '0;
        ch_awvalid      = '0; ch_arvalid = '0;
        ch_wdata        = '0; ch_wstrb  = '0;
        axi_awready     = 1'b0; axi_arready = 1'b0;
        axi_wready      = 1'b0; axi_wusero_id = '0; axi_wusero_last = 1'b0;
        axi_rdata       = '0; axi_rid = '0; axi_rlast = 1'b0; axi_rvalid = 1'b0;
        for (int i = 0; i < NC; i++) begin
            ch_awaddr[i*AW +: AW] = AW'(28'h100 + i);
            ch_araddr[i*AW +: AW] = AW'(28'h200 + i);
            ch_awlen[i*LW +: LW]  = 4'd1;
            ch_arlen[i*LW +: LW]  = 4'd1;
        end

        repeat (2) @(negedge core_clk);
        chk("rst_awvalid", DW'(axi_awvalid), 0);
        chk("rst_awready", DW'(ch_awready), 0);
        chk("rst_rvalid",  DW'(ch_rvalid), 0);
        chk("rst_err",     DW'(err_id), 0);

        // All channels request continuously, controller always ready
        resetn      = 1'b1;
        ch_awvalid  = 3'b111;
        axi_awready = 1'b1;
        for (int g = 0; g < 12; g++) begin
            q_rr.push_back(g % 3);
            q_fp.push_back(g / 4);
        end
        last_rr = -1;
        last_fp = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge core_clk);
            if (axi_awvalid) begin
                if (q_rr.size() == 0) chk("rr_extra_grant", 1, 0);
                else begin
                    e = q_rr.pop_front();
                    chk("rr_id", DW'(axi_awuser_id), DW'(e));
                    chk("rr_addr", DW'(axi_awaddr), DW'(28'h100 + e));
                    if (last_rr >= 0) chk("rr_gap", DW'(c - last_rr), 2);
                    last_rr = c;
                end
            end
            if (fp_awvalid) begin
                if (q_fp.size() == 0) chk("fp_extra_grant", 1, 0);
                else begin
                    e = q_fp.pop_front();
                    chk("fp_id", DW'(fp_awid), DW'(e));
                    if (last_fp >= 0) chk("fp_gap", DW'(c - last_fp), 2);
                    last_fp = c;
                end
            end
        end
        chk("rr_missing_grants", DW'(q_rr.size()), 0);
        chk("fp_missing_grants", DW'(q_fp.size()), 0);

        // Write data routing (wr_outs are 4 per channel here)
        ch_awvalid = '0;
        for (int i = 0; i < NC; i++) begin
            ch_wdata[i*DW +: DW] = {32{8'(8'h11 * (i + 1))}};
            ch_wstrb[i*32 +: 32] = 32'(32'h0000_000F << (4 * i));
        end
        ch_wdata[2*DW +: DW] = {32{8'hA5}};
        axi_wready    = 1'b1;
        axi_wusero_id = 4'd2;
        #1;
        chk("wdata_ch2", axi_wdata, {32{8'hA5}});
        chk("wstrb_ch2", DW'(axi_wstrb), DW'(32'h0000_0F00));
        chk("wready_ch2", DW'(ch_wready), DW'(3'b100));
        chk("wlast_none", DW'(ch_wlast), 0);
        @(negedge core_clk);
        axi_wusero_id = 4'd0;
        #1;
        chk("wdata_ch0", axi_wdata, {32{8'h11}});
        chk("wready_ch0", DW'(ch_wready), DW'(3'b001));
        @(negedge core_clk);
        axi_wusero_id   = 4'd2;
        axi_wusero_last = 1'b1;
        #1;
        chk("wlast_ch2", DW'(ch_wlast), DW'(3'b100));
        @(negedge core_clk);
        axi_wready      = 1'b0;
        axi_wusero_last = 1'b0;
        #1;
        chk("wr_outs2_dec", DW'(u_dut.u_aw.cnt_q[2]), 3);
        chk("wr_no_err", DW'(err_id), 0);

        resetn = 1'b0;
        @(negedge core_clk);
        resetn = 1'b1;
        chk("wr_outs0_rst", DW'(u_dut.u_aw.cnt_q[0]), 0);

        // ch1 issues three read bursts
        axi_arready = 1'b1;
        @(negedge core_clk);
        ch_arvalid = 3'b010;
        #1;
        n = 0;
        for (int c = 0; c < 12; c++) begin
            if (n == 3) ch_arvalid = '0;
            if (ch_arready[1]) n++;
            @(negedge core_clk);
            #1;
        end
        chk("ar_grants", DW'(n), 3);
        chk("rd_outs1_3", DW'(u_dut.u_ar.cnt_q[1]), 3);

        // Six beats for ch1, rlast on every second beat, with gaps
        nv = 0;
        nl = 0;
        for (int c = 0; c < 9; c++) begin
            @(negedge core_clk);
            if (c > 0) begin
                rb = q_rd.pop_front();
                chk("rvalid", DW'(ch_rvalid), DW'(rb.v));
                chk("rlast", DW'(ch_rlast), DW'(rb.l));
                if (rb.v != 0) chk("rdata", ch_rdata, rb.d);
                if (ch_rvalid[1]) nv++;
                if (ch_rlast[1]) nl++;
            end
            if (c < 8) begin
                beat       = (c % 3 != 2);
                lst        = beat && (c % 3 == 1);
                axi_rvalid = beat;
                axi_rlast  = lst;
                axi_rid    = 4'd1;
                axi_rdata  = {8{32'(32'hD000_0000 + c)}};
                rb.v = beat ? 3'b010 : 3'b000;
                rb.l = lst  ? 3'b010 : 3'b000;
                rb.d = axi_rdata;
                q_rd.push_back(rb);
            end else begin
                axi_rvalid = 1'b0;
                axi_rlast  = 1'b0;
            end
        end
        chk("rvalid_pulses", DW'(nv), 6);
        chk("rlast_pulses", DW'(nl), 3);
        chk("rd_outs1_0", DW'(u_dut.u_ar.cnt_q[1]), 0);
        chk("rd_no_err", DW'(err_id), 0);

        // Out-of-range read ID
        @(negedge core_clk);
        axi_rvalid = 1'b1;
        axi_rlast  = 1'b1;
        axi_rid    = 4'd5;
        @(negedge core_clk);
        axi_rvalid = 1'b0;
        axi_rlast  = 1'b0;
        chk("badid_rvalid", DW'(ch_rvalid), 0);
        chk("badid_err", DW'(err_id), 1);
        repeat (3) @(negedge core_clk);
        chk("badid_err_sticky", DW'(err_id), 1);
        resetn = 1'b0;
        #1;
        chk("err_cleared", DW'(err_id), 0);
        @(negedge core_clk);

        // Reset while a request sits in ISSUE with rr_ptr != 0
        resetn      = 1'b1;
        ch_awvalid  = 3'b111;
        axi_awready = 1'b1;
        @(negedge core_clk);
        chk("pre_issue_id0", DW'(axi_awuser_id), 0);
        @(negedge core_clk);
        axi_awready = 1'b0;
        @(negedge core_clk);
        chk("issue_valid", DW'(axi_awvalid), 1);
        chk("issue_id1", DW'(axi_awuser_id), 1);
        resetn = 1'b0;
        #1;
        chk("midrst_awvalid", DW'(axi_awvalid), 0);
        chk("midrst_awready", DW'(ch_awready), 0);
        @(negedge core_clk);
        resetn = 1'b1;
        #1;
        chk("post_rst_grant_ch0", DW'(ch_awready), DW'(3'b001));
        @(negedge core_clk);
        chk("post_rst_id0", DW'(axi_awuser_id), 0);
        ch_awvalid = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
